// File: rtl/useq_pkg.sv
// Shared definitions for the microcode sequencer: seq codes, control-word field
// positions and interrupt vector bits.
package useq_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH     = 3'b000,
        SEQ_NEXT      = 3'b001,
        SEQ_FINISH    = 3'b010,
        SEQ_NEXT_SAVE = 3'b011,
        SEQ_BRANCH    = 3'b100,
        SEQ_CALL      = 3'b101,
        SEQ_RETURN    = 3'b110,
        SEQ_HOLD      = 3'b111
    } seq_e;

    // Control word layout, LSB first: seq, next, fin, we.
    localparam int SEQ_LSB  = 0;
    localparam int SEQ_MSB  = 2;
    localparam int NEXT_LSB = 3;

    function automatic int next_msb(input int uaw);
        return NEXT_LSB + uaw - 3;
    endfunction

    function automatic int fin_lsb(input int uaw);
        return NEXT_LSB + uaw - 2;
    endfunction

    function automatic int fin_msb(input int uaw, input int finw);
        return fin_lsb(uaw) + finw - 1;
    endfunction

    function automatic int we_bit(input int uaw, input int finw);
        return fin_lsb(uaw) + finw;
    endfunction

    // Low bits shared by the NMI and IRQ entry vectors; bit UAW-2 selects NMI.
    localparam logic [6:0] INT_VEC_LO = 7'b1100000;

endpackage

// File: rtl/useq_stack.sv
// Micro-call return-address LIFO. Overflow rewrites the top entry, underflow
// leaves the pointer at zero; both set a sticky error flag.
module useq_stack
    import useq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  sp_q, sp_d, sp_m1;
    logic         err_q, err_d;

    assign sp_m1   = sp_q - (PW+1)'(1);
    assign full_o  = (sp_q == (PW+1)'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_o   = mem_q[sp_m1[PW-1:0]];
    assign err_o   = err_q;

    always_comb begin
        sp_d  = sp_q;
        err_d = err_q;
        if (push_i) begin
            if (full_o) err_d = 1'b1;
            else        sp_d  = sp_q + (PW+1)'(1);
        end else if (pop_i) begin
            if (empty_o) err_d = 1'b1;
            else         sp_d  = sp_m1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Storage carries no reset; entries are only read below the pointer.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            if (full_o) mem_q[sp_m1[PW-1:0]] <= data_i;
            else        mem_q[sp_q[PW-1:0]]  <= data_i;
        end
    end

endmodule

// File: rtl/useq_sequencer.sv
// Microcode sequencer: picks the next ROM micro-address from the current control
// word, opcode, interrupts and rdy. Micro-call stack built only with USEQ_MICROCALL_EN.
module useq_sequencer
    import useq_pkg::*;
#(
    parameter int             OPW         = 8,
    parameter int             UAW         = 9,
    parameter int             CW          = 36,
    parameter int             FINW        = 5,
    parameter int             STACK_DEPTH = 2,
    parameter logic [UAW-1:0] RESET_UA    = 'h1F0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rdy,
    input  logic            irq,
    input  logic            nmi,
    input  logic            I,
    input  logic            D,
    input  logic            cond,
    input  logic [OPW-1:0]  opcode,
    input  logic [CW-1:0]   ctrl,
    output logic [UAW-1:0]  uaddr,
    output logic            rom_en,
    output logic            sync,
    output logic            int_take,
    output logic            WE,
    output logic [FINW-1:0] finish,
    output logic            ustack_err
);

    localparam int NEXT_MSB = next_msb(UAW);
    localparam int FIN_LSB  = fin_lsb(UAW);
    localparam int FIN_MSB  = fin_msb(UAW, FINW);
    localparam int WE_BIT   = we_bit(UAW, FINW);

    seq_e           seq;
    logic [UAW-3:0] nxt;
    logic [FINW-1:0] fin_f;
    logic           we_f;
    logic           unused_ctrl;

    assign seq         = seq_e'(ctrl[SEQ_MSB:SEQ_LSB]);
    assign nxt         = ctrl[NEXT_MSB:NEXT_LSB];
    assign fin_f       = ctrl[FIN_MSB:FIN_LSB];
    assign we_f        = ctrl[WE_BIT];
    assign unused_ctrl = ^ctrl[CW-1:WE_BIT+1];

    logic [UAW-1:0]  cur_q, ua_d, cur_inc, bank_ua, fin_ua, op_ua, nmi_ua, irq_ua;
    logic [FINW-1:0] finish_q, finish_d;
    logic            nmi_q, nmi_pend_q, nmi_pend_d, nmi_clr;
    logic            we_q;
    logic            fetch;

    assign cur_inc = cur_q + UAW'(1);
    assign bank_ua = {1'b1, D, nxt};
    assign fin_ua  = {1'b1, D, 2'b10, (UAW-4)'(finish_q)};
    assign op_ua   = {1'b0, opcode};
    assign nmi_ua  = {1'b1, 1'b1, (UAW-2)'(INT_VEC_LO)};
    assign irq_ua  = {1'b1, 1'b0, (UAW-2)'(INT_VEC_LO)};

`ifdef USEQ_MICROCALL_EN
    logic           push, pop, stk_empty, stk_err, unused_stk_full;
    logic [UAW-1:0] stk_top;

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UAW)
    ) u_stack (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (cur_inc),
        .top_o   (stk_top),
        .full_o  (unused_stk_full),
        .empty_o (stk_empty),
        .err_o   (stk_err)
    );
    assign ustack_err = stk_err;
`else
    assign ustack_err = 1'b0;
`endif

    always_comb begin
        ua_d     = cur_q;
        sync     = 1'b0;
        int_take = 1'b0;
        finish_d = finish_q;
        nmi_clr  = 1'b0;
        fetch    = 1'b0;
`ifdef USEQ_MICROCALL_EN
        push     = 1'b0;
        pop      = 1'b0;
`endif
        if (reset) begin
            ua_d = RESET_UA;
        end else if (rdy) begin
            case (seq)
                SEQ_FETCH:     fetch = 1'b1;
                SEQ_NEXT:      ua_d  = bank_ua;
                SEQ_FINISH:    ua_d  = fin_ua;
                SEQ_NEXT_SAVE: begin
                    ua_d     = bank_ua;
                    finish_d = fin_f;
                end
                SEQ_BRANCH:    ua_d  = cond ? bank_ua : cur_inc;
                SEQ_CALL: begin
                    ua_d = bank_ua;
`ifdef USEQ_MICROCALL_EN
                    push = 1'b1;
`endif
                end
                SEQ_RETURN: begin
`ifdef USEQ_MICROCALL_EN
                    // Underflow falls back to an opcode fetch without interrupt checks.
                    pop  = 1'b1;
                    ua_d = stk_empty ? op_ua : stk_top;
                    sync = stk_empty;
`else
                    fetch = 1'b1;
`endif
                end
                SEQ_HOLD:      ua_d  = cur_q;
                default:       ua_d  = cur_q;
            endcase

            if (fetch) begin
                if (nmi_pend_q) begin
                    ua_d     = nmi_ua;
                    int_take = 1'b1;
                    nmi_clr  = 1'b1;
                end else if (irq && !I) begin
                    ua_d     = irq_ua;
                    int_take = 1'b1;
                end else begin
                    ua_d = op_ua;
                    sync = 1'b1;
                end
            end
        end
    end

    // A fresh NMI edge on the same cycle as the clear keeps the request pending.
    assign nmi_pend_d = (nmi && !nmi_q) || (nmi_pend_q && !nmi_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q      <= RESET_UA;
            finish_q   <= '0;
            nmi_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            cur_q      <= ua_d;
            finish_q   <= finish_d;
            nmi_q      <= nmi;
            nmi_pend_q <= nmi_pend_d;
            if (rdy) we_q <= we_f;
        end
    end

    assign uaddr  = ua_d;
    assign rom_en = rdy | reset;
    assign WE     = we_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_useq_sequencer.sv
// Directed-vector bench for useq_sequencer; expectations follow USEQ_MICROCALL_EN.
module tb_useq_sequencer;

    localparam logic [2:0] F = 3'd0, NX = 3'd1, FI = 3'd2, NS = 3'd3,
                           BR = 3'd4, CA = 3'd5, RE = 3'd6, HO = 3'd7;
`ifdef USEQ_MICROCALL_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, rdy, irq, nmi, I, D, cond;
    logic [7:0]  opcode;
    logic [35:0] ctrl;
    logic [8:0]  uaddr;
    logic        rom_en, sync, int_take, WE, ustack_err;
    logic [4:0]  finish;

    int checks   = 0;
    int failures = 0;

    useq_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .rdy        (rdy),
        .irq        (irq),
        .nmi        (nmi),
        .I          (I),
        .D          (D),
        .cond       (cond),
        .opcode     (opcode),
        .ctrl       (ctrl),
        .uaddr      (uaddr),
        .rom_en     (rom_en),
        .sync       (sync),
        .int_take   (int_take),
        .WE         (WE),
        .finish     (finish),
        .ustack_err (ustack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, rdy, irq, nmi, i, d, cond;
        logic [7:0] op;
        logic [2:0] seq;
        logic [6:0] nx;
        logic [4:0] fn;
        logic       we;
        logic [8:0] eua;
        logic       esync, eint, ewe;
        logic [4:0] efin;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, rdy_v, irq_v, nmi_v, i_v, d_v, cond_v,
                                input logic [7:0] op, input logic [2:0] sq,
                                input logic [6:0] nx, input logic [4:0] fn, input logic we,
                                input logic [8:0] eua, input logic esync, eint, ewe,
                                input logic [4:0] efin, input logic eerr);
        vec_t v;
        v.rst = rst; v.rdy = rdy_v; v.irq = irq_v; v.nmi = nmi_v; v.i = i_v; v.d = d_v;
        v.cond = cond_v; v.op = op; v.seq = sq; v.nx = nx; v.fn = fn; v.we = we;
        v.eua = eua; v.esync = esync; v.eint = eint; v.ewe = ewe; v.efin = efin; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset  = v.rst;  rdy = v.rdy; irq = v.irq; nmi = v.nmi;
        I      = v.i;    D   = v.d;   cond = v.cond; opcode = v.op;
        ctrl   = {20'hA5C3E, v.we, v.fn, v.nx, v.seq};
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " uaddr"},      32'(uaddr),      32'(v.eua));
        chk({tag, " sync"},       32'(sync),       32'(v.esync));
        chk({tag, " int_take"},   32'(int_take),   32'(v.eint));
        chk({tag, " rom_en"},     32'(rom_en),     32'(v.rdy | v.rst));
        chk({tag, " WE"},         32'(WE),         32'(v.ewe));
        chk({tag, " finish"},     32'(finish),     32'(v.efin));
        chk({tag, " ustack_err"}, 32'(ustack_err), 32'(v.eerr));
    endtask

    initial begin
        // rst rdy irq nmi I D cond  op  seq nx fn we | ua sync int we fin err
        tbl.push_back(mk(1,1,0,0,0,0,0, 8'h00, F,  7'h00, 5'd0, 0, 9'h1F0, 0,0,0, 5'd0, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'hA9, F,  7'h00, 5'd0, 1, 9'h0A9, 1,0,0, 5'd0, 0));
        tbl.push_back(mk(0,1,0,0,1,1,0, 8'h00, NS, 7'h12, 5'd5, 0, 9'h192, 0,0,1, 5'd0, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, NX, 7'h40, 5'd0, 0, 9'h140, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, BR, 7'h20, 5'd0, 0, 9'h141, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, NX, 7'h40, 5'd0, 0, 9'h140, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,1, 8'h00, BR, 7'h20, 5'd0, 0, 9'h120, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,1,0, 8'h00, FI, 7'h00, 5'd0, 0, 9'h1C5, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,1,0, 8'h00, HO, 7'h00, 5'd0, 0, 9'h1C5, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,1,0, 8'h00, NX, 7'h7F, 5'd0, 0, 9'h1FF, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, BR, 7'h55, 5'd0, 0, 9'h000, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,1,0,1,0,0, 8'h55, F,  7'h00, 5'd0, 0, 9'h055, 1,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,1,0,0,0,0, 8'h55, F,  7'h00, 5'd0, 0, 9'h160, 0,1,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,1,1,0,0, 8'h00, NX, 7'h00, 5'd0, 0, 9'h100, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, NX, 7'h01, 5'd0, 0, 9'h101, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, NX, 7'h02, 5'd0, 0, 9'h102, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h3C, F,  7'h00, 5'd0, 0, 9'h1E0, 0,1,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h3C, F,  7'h00, 5'd0, 0, 9'h03C, 1,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,1,1,0,0, 8'h00, NX, 7'h00, 5'd0, 0, 9'h100, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,1,1,0,0,0, 8'h3C, F,  7'h00, 5'd0, 0, 9'h1E0, 0,1,0, 5'd5, 0));
        tbl.push_back(mk(0,1,1,1,0,0,0, 8'h3C, F,  7'h00, 5'd0, 0, 9'h160, 0,1,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 8'h77, F,  7'h00, 5'd0, 0, 9'h077, 1,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,1,1,0,0, 8'h00, NX, 7'h00, 5'd0, 0, 9'h100, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h00, NX, 7'h03, 5'd0, 0, 9'h103, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,1,1,0,0, 8'h11, F,  7'h00, 5'd0, 0, 9'h1E0, 0,1,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,1,1,0,0, 8'h11, F,  7'h00, 5'd0, 0, 9'h1E0, 0,1,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h11, F,  7'h00, 5'd0, 0, 9'h011, 1,0,0, 5'd5, 0));
        tbl.push_back(mk(0,1,0,0,1,1,0, 8'h00, NS, 7'h12, 5'd9, 1, 9'h192, 0,0,0, 5'd5, 0));
        tbl.push_back(mk(0,0,0,0,1,0,0, 8'h22, F,  7'h00, 5'd0, 0, 9'h192, 0,0,1, 5'd9, 0));
        tbl.push_back(mk(0,0,0,1,1,0,0, 8'h22, F,  7'h00, 5'd0, 0, 9'h192, 0,0,1, 5'd9, 0));
        tbl.push_back(mk(0,0,0,0,1,0,0, 8'h22, F,  7'h00, 5'd0, 0, 9'h192, 0,0,1, 5'd9, 0));
        tbl.push_back(mk(0,0,0,0,1,0,0, 8'h22, F,  7'h00, 5'd0, 0, 9'h192, 0,0,1, 5'd9, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h22, F,  7'h00, 5'd0, 0, 9'h1E0, 0,1,1, 5'd9, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h22, F,  7'h00, 5'd0, 1, 9'h022, 1,0,0, 5'd9, 0));
        tbl.push_back(mk(1,0,0,0,1,0,0, 8'h00, NX, 7'h00, 5'd0, 0, 9'h1F0, 0,0,1, 5'd9, 0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 8'h5A, F,  7'h00, 5'd0, 0, 9'h05A, 1,0,0, 5'd0, 0));

        // First reset cycle: registered outputs are still unknown, so nothing is checked.
        @(negedge clk);
        drive(tbl[0]);

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k], $sformatf("v%0d", k));

        // Reset during a call at depth 1, then a RETURN on the emptied stack.
        apply(mk(0,1,0,0,1,0,0, 8'h33, CA, 7'h10, 5'd0, 0, 9'h110, 0,0,0, 5'd0, 0), "s1 call");
        apply(mk(1,1,0,0,1,0,0, 8'h33, CA, 7'h10, 5'd0, 0, 9'h1F0, 0,0,0, 5'd0, 0), "s2 reset");
        apply(mk(0,1,0,0,1,0,0, 8'h33, RE, 7'h00, 5'd0, 0, 9'h033, 1,0,0, 5'd0, 0), "s3 ret");
        apply(mk(0,1,0,0,1,0,0, 8'h33, HO, 7'h00, 5'd0, 0, 9'h033, 0,0,0, 5'd0, MC), "s4 hold");
        apply(mk(1,1,0,0,1,0,0, 8'h44, HO, 7'h00, 5'd0, 0, 9'h1F0, 0,0,0, 5'd0, MC), "s5 reset");

        // Three nested calls on a two-entry stack, then unwind past the bottom.
        apply(mk(0,1,0,0,1,0,0, 8'h44, CA, 7'h01, 5'd0, 0, 9'h101, 0,0,0, 5'd0, 0), "s6 call1");
        apply(mk(0,1,0,0,1,0,0, 8'h44, CA, 7'h02, 5'd0, 0, 9'h102, 0,0,0, 5'd0, 0), "s7 call2");
        apply(mk(0,1,0,0,1,0,0, 8'h44, CA, 7'h03, 5'd0, 0, 9'h103, 0,0,0, 5'd0, 0), "s8 call3");
        apply(mk(0,1,0,0,1,0,0, 8'h44, RE, 7'h00, 5'd0, 0, MC ? 9'h103 : 9'h044,
                 !MC,0,0, 5'd0, MC), "s9 ret1");
        apply(mk(0,1,0,0,1,0,0, 8'h44, RE, 7'h00, 5'd0, 0, MC ? 9'h1F1 : 9'h044,
                 !MC,0,0, 5'd0, MC), "s10 ret2");
        apply(mk(0,1,0,0,1,0,0, 8'h44, RE, 7'h00, 5'd0, 0, 9'h044, 1,0,0, 5'd0, MC), "s11 ret3");
        apply(mk(0,0,0,0,1,0,0, 8'h44, CA, 7'h05, 5'd0, 1, 9'h044, 0,0,0, 5'd0, MC), "s12 stall");
        apply(mk(0,1,0,0,1,0,0, 8'h44, HO, 7'h00, 5'd0, 0, 9'h044, 0,0,0, 5'd0, MC), "s13 hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
